// File: rtl/estagio_busca_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package estagio_busca_pkg;

   localparam int          TAMANHO_MEM_PADRAO = 64;
   localparam int          LARGURA_PC         = 64;
   localparam int          LARGURA_INSTR      = 32;
   localparam logic [31:0] NOP                = 32'b0;

   typedef enum logic {
      BUSCA = 1'b0,
      FIM   = 1'b1
   } estado_t;

endpackage

// File: rtl/estagio_busca_if_id.sv
// IF/ID pipeline register: flush inserts a NOP bubble, load captures a fetch, otherwise hold.
module registrador_if_id
   import estagio_busca_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     limpar_i,
   input  logic                     carregar_i,
   input  logic [LARGURA_INSTR-1:0] instrucao_i,
   input  logic [LARGURA_PC-1:0]    pc_i,
   output logic [LARGURA_INSTR-1:0] instrucao_o,
   output logic [LARGURA_PC-1:0]    pc_o,
   output logic                     valido_o
);

   logic [LARGURA_INSTR-1:0] instrucao_q;
   logic [LARGURA_PC-1:0]    pc_q;
   logic                     valido_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instrucao_q <= NOP;
         pc_q        <= '0;
         valido_q    <= 1'b0;
      end else if (limpar_i) begin
         instrucao_q <= NOP;
         pc_q        <= '0;
         valido_q    <= 1'b0;
      end else if (carregar_i) begin
         instrucao_q <= instrucao_i;
         pc_q        <= pc_i;
         valido_q    <= 1'b1;
      end
   end

   assign instrucao_o = instrucao_q;
   assign pc_o        = pc_q;
   assign valido_o    = valido_q;

endmodule

// File: rtl/estagio_busca.sv
// Fetch stage: PC register, BUSCA/FIM control and delivered-instruction counter around the IF/ID register.
module estagio_busca
   import estagio_busca_pkg::*;
#(
   parameter int              TAMANHO_MEM = TAMANHO_MEM_PADRAO,
   parameter logic [63:0]     PC_INICIAL  = 64'd0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     parar,
   input  logic                     desvio,
   input  logic [LARGURA_PC-1:0]    endereco_desvio,
   input  logic [LARGURA_INSTR-1:0] instrucao_mem,
   output logic [LARGURA_PC-1:0]    pc,
   output logic [LARGURA_INSTR-1:0] instrucao_id,
   output logic [LARGURA_PC-1:0]    pc_id,
   output logic                     valido_id,
   output logic                     fim,
   output logic [31:0]              contagem
);

   localparam logic [LARGURA_PC-1:0] LIMITE = LARGURA_PC'(TAMANHO_MEM);

   estado_t                 estado_q, estado_d;
   logic [LARGURA_PC-1:0]   pc_q, pc_d;
   logic [31:0]             contagem_q, contagem_d;
   logic                    carregar, limpar;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q   <= BUSCA;
         pc_q       <= PC_INICIAL;
         contagem_q <= '0;
      end else begin
         estado_q   <= estado_d;
         pc_q       <= pc_d;
         contagem_q <= contagem_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      estado_d   = estado_q;
      pc_d       = pc_q;
      contagem_d = contagem_q;
      carregar   = 1'b0;
      limpar     = 1'b0;
      if (desvio) begin
         pc_d     = endereco_desvio;
         limpar   = 1'b1;
         estado_d = BUSCA;
      end else if (!parar && estado_q == BUSCA) begin
         if (pc_q < LIMITE) begin
            carregar = 1'b1;
            pc_d     = pc_q + 1'b1;
            if (contagem_q != '1) contagem_d = contagem_q + 1'b1;
         end else begin
            // PC walked off the memory: park here until redirected.
            limpar   = 1'b1;
            estado_d = FIM;
         end
      end
   end

   registrador_if_id u_if_id (
      .clock       (clock),
      .reset       (reset),
      .limpar_i    (limpar),
      .carregar_i  (carregar),
      .instrucao_i (instrucao_mem),
      .pc_i        (pc_q),
      .instrucao_o (instrucao_id),
      .pc_o        (pc_id),
      .valido_o    (valido_id)
   );

   assign pc       = pc_q;
   assign fim      = (estado_q == FIM);
   assign contagem = contagem_q;

endmodule

// File: tb/tb_estagio_busca.sv
// Scoreboard bench for estagio_busca: the driver queues expected deliveries, the monitor checks them.
module tb_estagio_busca;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        parar = 1'b0;
   logic        desvio = 1'b0;
   logic [63:0] endereco_desvio = '0;
   logic [31:0] instrucao_mem;
   logic [63:0] pc;
   logic [31:0] instrucao_id;
   logic [63:0] pc_id;
   logic        valido_id;
   logic        fim;
   logic [31:0] contagem;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } item_t;

   item_t       fila[$];
   logic [31:0] mem [64];
   int          total = 0;
   int          bad   = 0;
   logic        ult_parado = 1'b0;

   logic [63:0] exp_pc;
   logic [31:0] exp_cnt;
   logic        exp_fim;

   always #5 clock = ~clock;

   assign instrucao_mem = (pc < 64'd64) ? mem[pc[5:0]] : 32'h0;

   estagio_busca dut (
      .clock           (clock),
      .reset           (reset),
      .parar           (parar),
      .desvio          (desvio),
      .endereco_desvio (endereco_desvio),
      .instrucao_mem   (instrucao_mem),
      .pc              (pc),
      .instrucao_id    (instrucao_id),
      .pc_id           (pc_id),
      .valido_id       (valido_id),
      .fim             (fim),
      .contagem        (contagem)
   );

   task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
      total++;
      if (atual !== esperado) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
      end
   endtask

   // One clock: update the reference model, queue any delivery, return at the next falling edge.
   task automatic tick(input logic p, input logic d, input logic [63:0] e);
      parar = p;
      desvio = d;
      endereco_desvio = e;
      if (d) begin
         exp_pc  = e;
         exp_fim = 1'b0;
      end else if (!p && !exp_fim) begin
         if (exp_pc < 64'd64) begin
            fila.push_back('{instr: mem[exp_pc[5:0]], pc: exp_pc});
            exp_pc  = exp_pc + 1;
            exp_cnt = exp_cnt + 1;
         end else begin
            exp_fim = 1'b1;
         end
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic modelo_reset();
      exp_pc  = 64'd0;
      exp_cnt = 32'd0;
      exp_fim = 1'b0;
   endtask

   always @(posedge clock) ult_parado <= parar && !desvio;

   always @(negedge clock) begin
      if (!reset && valido_id && !ult_parado) begin
         if (fila.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_delivery: got pc_id=%0h nothing expected", pc_id);
         end else begin
            item_t it;
            it = fila.pop_front();
            check("sb_instr", 64'(instrucao_id), 64'(it.instr));
            check("sb_pc_id", pc_id, it.pc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 | k;
      mem[0] = 32'h0000_0000;
      mem[1] = 32'h0070_2083;
      modelo_reset();

      #2;
      check("rst_pc", pc, 64'd0);
      check("rst_instr", 64'(instrucao_id), 64'd0);
      check("rst_pc_id", pc_id, 64'd0);
      check("rst_valido", 64'(valido_id), 64'd0);
      check("rst_fim", 64'(fim), 64'd0);
      check("rst_cnt", 64'(contagem), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Free run: word 0 is a valid instruction, word 1 follows.
      tick(0, 0, 0);
      check("w0_valido", 64'(valido_id), 64'd1);
      tick(0, 0, 0);
      check("e2_instr", 64'(instrucao_id), 64'h0070_2083);
      check("e2_pc_id", pc_id, 64'd1);
      check("e2_cnt", 64'(contagem), 64'd2);
      tick(0, 0, 0);
      check("pre_stall_pc", pc, 64'd3);

      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 0);
         check("stall_pc", pc, 64'd3);
         check("stall_pc_id", pc_id, 64'd2);
         check("stall_cnt", 64'(contagem), 64'd3);
      end
      tick(0, 0, 0);
      check("release_pc_id", pc_id, 64'd3);
      tick(0, 0, 0);
      check("release_pc_id2", pc_id, 64'd4);

      // Redirect: one bubble, then the target.
      tick(0, 1, 64'd9);
      check("dsv_pc", pc, 64'd9);
      check("dsv_valido", 64'(valido_id), 64'd0);
      check("dsv_instr", 64'(instrucao_id), 64'd0);
      tick(0, 0, 0);
      check("dsv_tgt_pc_id", pc_id, 64'd9);
      check("dsv_tgt_valido", 64'(valido_id), 64'd1);

      // Redirect wins over stall.
      tick(1, 1, 64'd20);
      check("dsvpar_pc", pc, 64'd20);
      check("dsvpar_valido", 64'(valido_id), 64'd0);
      tick(0, 0, 0);
      check("dsvpar_pc_id", pc_id, 64'd20);
      check("dsvpar_cnt", 64'(contagem), 64'd7);

      // Asynchronous reset between edges while a valid instruction is held.
      check("pre_arst_valido", 64'(valido_id), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("arst_pc", pc, 64'd0);
      check("arst_valido", 64'(valido_id), 64'd0);
      check("arst_cnt", 64'(contagem), 64'd0);
      modelo_reset();
      #1 reset = 1'b0;

      // Run off the end of memory into FIM.
      for (int i = 0; i < 64; i++) tick(0, 0, 0);
      check("end_pc", pc, 64'd64);
      check("end_pc_id", pc_id, 64'd63);
      tick(0, 0, 0);
      check("fim_fim", 64'(fim), 64'd1);
      check("fim_valido", 64'(valido_id), 64'd0);
      check("fim_pc", pc, 64'd64);
      check("fim_cnt", 64'(contagem), 64'd64);
      tick(0, 0, 0);
      check("fim_hold_pc", pc, 64'd64);
      check("fim_hold", 64'(fim), 64'd1);

      tick(0, 1, 64'd0);
      check("leave_fim", 64'(fim), 64'd0);
      check("leave_pc", pc, 64'd0);
      tick(0, 0, 0);
      check("refetch_valido", 64'(valido_id), 64'd1);
      check("refetch_pc_id", pc_id, 64'd0);
      check("refetch_cnt", 64'(contagem), 64'd65);

      // Redirect out of range: bubble, then FIM on the next free edge.
      tick(0, 1, 64'd100);
      check("oor_fim0", 64'(fim), 64'd0);
      tick(0, 0, 0);
      check("oor_fim1", 64'(fim), 64'd1);
      check("oor_pc", pc, 64'd100);

      check("sb_drained", 64'(fila.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/estagio_busca.md
# estagio_busca

Instruction-fetch stage of the single-cycle-memory RISC-V datapath. Owns the program counter, drives it to the combinational instruction memory (64 words, word-indexed, returns 0 for out-of-range addresses), and latches the returned word plus its PC into an IF/ID register for the decoder. Supports stall, redirect (branch/jump flush) and a terminal halt state when the PC leaves the memory range.

## Interface
- TAMANHO_MEM, 64: number of instruction words; valid PC range 0..TAMANHO_MEM-1.
- PC_INICIAL, 0: PC value loaded on reset.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- parar  in  1  stall from downstream; hold PC and IF/ID contents.
- desvio  in  1  redirect request; has priority over parar.
- endereco_desvio  in  64  new PC (word index) when desvio=1.
- instrucao_mem  in  32  word returned by instruction memory for current pc, same cycle.
- pc  out  64  registered PC, drives the memory address.
- instrucao_id  out  32  latched instruction for decode.
- pc_id  out  64  PC of instrucao_id.
- valido_id  out  1  instrucao_id is a real fetched instruction.
- fim  out  1  high while in state FIM.
- contagem  out  32  number of instructions delivered (saturating).

## Operation
- States: BUSCA, FIM. Reset -> BUSCA.
- Reset values: pc=PC_INICIAL, instrucao_id=0, pc_id=0, valido_id=0, fim=0, contagem=0.
- Priority per edge: reset > desvio > parar > normal.
- desvio=1 (either state): pc<=endereco_desvio; instrucao_id<=0 (NOP), pc_id<=0, valido_id<=0; state<=BUSCA. The instruction currently at the memory output is discarded.
- parar=1, desvio=0: pc, instrucao_id, pc_id, valido_id, contagem unchanged; state unchanged.
- BUSCA, no stall/redirect, pc < TAMANHO_MEM: instrucao_id<=instrucao_mem, pc_id<=pc, valido_id<=1, pc<=pc+1 (64-bit, wraps mod 2^64), contagem<=contagem+1 unless already 0xFFFFFFFF.
- BUSCA, no stall/redirect, pc >= TAMANHO_MEM: state<=FIM, valido_id<=0, instrucao_id<=0, pc held, contagem unchanged.
- FIM: pc held, valido_id=0; leaves only via desvio (to BUSCA) or reset. A redirect to an out-of-range address re-enters FIM on the following non-stalled edge.
- Instruction word 0 is fetched and delivered as a normal valid instruction (valido_id=1); it is not a halt.

## Timing
- pc is a register; memory read is combinational, so instrucao_mem is valid in the cycle pc is presented.
- Fetch latency 1 cycle: word at pc=k appears on instrucao_id with pc_id=k after the edge where pc=k was sampled.
- Redirect: one bubble cycle (valido_id=0) follows the edge with desvio=1; target instruction valid on the next edge after that.
- Stall holds indefinitely; releasing parar resumes with the held pc, no instruction lost or duplicated.
- fim rises on the edge that enters FIM, same edge valido_id falls.
- Reset asserted mid-stream: outputs return to reset values immediately, without waiting for clock.

## Structure
- Shared package/include: TAMANHO_MEM default, state encodings BUSCA/FIM, constant NOP = 32'b0, PC width 64, instruction width 32.
- One natural sub-module: registrador_if_id (instrucao_id, pc_id, valido_id with load/flush/hold controls); PC, FSM and counter stay in the top.

## Test plan
- Reset then free-run with memory program (word1=0x00702083): pc 0,1,2...; after edge 2, instrucao_id=0x00702083, pc_id=1, valido_id=1, contagem=2.
- parar high for 3 cycles at pc=3: pc stays 3, IF/ID frozen 3 cycles; on release pc_id sequence continues 2,3,4 without gap or repeat.
- desvio=1 with endereco_desvio=5 while pc=2: next cycle pc=5, valido_id=0, instrucao_id=0; following cycle pc_id=5, valido_id=1.
- desvio and parar both high: redirect taken (pc=target, bubble), stall ignored.
- Free-run to pc=64: enters FIM, fim=1, valido_id=0, pc stays 64, contagem=64; desvio to 0 returns to BUSCA and refetches word 0.
- Assert reset asynchronously between edges while valido_id=1: pc=0, valido_id=0, contagem=0 before next edge.
